// File: rtl/morse_char_sequencer_if.sv
// rtl/morse_char_sequencer_if.sv - character handshake bundle for the Morse sequencer
interface morse_char_sequencer_if;
    logic       char_valid;
    logic [1:0] char_code;
    logic       char_ready;

    modport master (output char_valid, output char_code, input char_ready);
    modport slave  (input char_valid, input char_code, output char_ready);
endinterface

// File: rtl/morse_char_sequencer.sv
// rtl/morse_char_sequencer.sv - serialises S/O/GAP codes into a keyed Morse bit stream
// Optional autonomous SOS beacon enabled by defining MORSE_BEACON_EN.
module morse_char_sequencer #(
    parameter int unsigned UNIT_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    morse_char_sequencer_if.slave        bus,
`ifdef MORSE_BEACON_EN
    input  logic                         beacon_en,
`endif
    output logic                         key_out,
    output logic                         busy,
    output logic                         char_done
);
    typedef enum logic [1:0] {ST_IDLE, ST_MARK, ST_SPACE, ST_GAP} state_t;

    localparam logic [7:0] UNIT_LAST = 8'(UNIT_CYCLES - 1);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_unit_cnt, w_unit_nxt;
    logic [1:0] r_len_cnt, w_len_nxt;
    logic [1:0] r_elem_cnt, w_elem_nxt;
    logic       r_is_o, w_is_o_nxt;
    logic       r_key;
    logic       w_unit_end, w_char_end, w_slot, w_accept;
    logic [1:0] w_code;

    assign w_unit_end = (r_unit_cnt == UNIT_LAST);
    assign w_char_end = w_unit_end && (r_len_cnt == 2'd0) &&
                        (((r_state == ST_SPACE) && (r_elem_cnt == 2'd1)) || (r_state == ST_GAP));
    // A new character may start whenever the previous one is on its final clock.
    assign w_slot     = ((r_state == ST_IDLE) || w_char_end) && !rst;

`ifdef MORSE_BEACON_EN
    logic [2:0] r_bcn_ptr;
    logic [1:0] w_bcn_code;

    always_comb begin
        w_bcn_code = 2'b10;
        case (r_bcn_ptr)
            3'd0:    w_bcn_code = 2'b00;
            3'd2:    w_bcn_code = 2'b01;
            3'd4:    w_bcn_code = 2'b00;
            default: w_bcn_code = 2'b10;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_bcn_ptr <= 3'd0;
        else if (!beacon_en)
            r_bcn_ptr <= 3'd0;
        else if (w_slot)
            r_bcn_ptr <= (r_bcn_ptr == 3'd6) ? 3'd0 : r_bcn_ptr + 3'd1;
    end

    assign w_accept       = w_slot && (beacon_en || bus.char_valid);
    assign w_code         = beacon_en ? w_bcn_code : bus.char_code;
    assign bus.char_ready = w_slot && !beacon_en;
`else
    assign w_accept       = w_slot && bus.char_valid;
    assign w_code         = bus.char_code;
    assign bus.char_ready = w_slot;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len_cnt;
        w_elem_nxt  = r_elem_cnt;
        w_is_o_nxt  = r_is_o;
        w_unit_nxt  = ((r_state == ST_IDLE) || w_unit_end) ? 8'd0 : r_unit_cnt + 8'd1;
        case (r_state)
            ST_MARK: begin
                if (w_unit_end) begin
                    if (r_len_cnt == 2'd0)
                        w_state_nxt = ST_SPACE;
                    else
                        w_len_nxt = r_len_cnt - 2'd1;
                end
            end
            ST_SPACE: begin
                if (w_unit_end && (r_elem_cnt > 2'd1)) begin
                    w_state_nxt = ST_MARK;
                    w_elem_nxt  = r_elem_cnt - 2'd1;
                    w_len_nxt   = r_is_o ? 2'd2 : 2'd0;
                end
            end
            ST_GAP: begin
                if (w_unit_end && (r_len_cnt != 2'd0))
                    w_len_nxt = r_len_cnt - 2'd1;
            end
            default: ;
        endcase
        // Character boundary: either load the next code or fall back to idle.
        if ((r_state == ST_IDLE) || w_char_end) begin
            if (w_accept) begin
                if (w_code[1]) begin
                    w_state_nxt = ST_GAP;
                    w_len_nxt   = 2'd1;
                    w_elem_nxt  = 2'd0;
                    w_is_o_nxt  = 1'b0;
                end else begin
                    w_state_nxt = ST_MARK;
                    w_len_nxt   = w_code[0] ? 2'd2 : 2'd0;
                    w_elem_nxt  = 2'd3;
                    w_is_o_nxt  = w_code[0];
                end
            end else begin
                w_state_nxt = ST_IDLE;
                w_len_nxt   = 2'd0;
                w_elem_nxt  = 2'd0;
                w_is_o_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_unit_cnt <= 8'd0;
            r_len_cnt  <= 2'd0;
            r_elem_cnt <= 2'd0;
            r_is_o     <= 1'b0;
            r_key      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_unit_cnt <= w_unit_nxt;
            r_len_cnt  <= w_len_nxt;
            r_elem_cnt <= w_elem_nxt;
            r_is_o     <= w_is_o_nxt;
            r_key      <= (w_state_nxt == ST_MARK);
        end
    end

    assign key_out   = r_key;
    assign busy      = (r_state != ST_IDLE);
    assign char_done = w_char_end;
endmodule

// File: tb/tb_morse_char_sequencer.sv
// tb/tb_morse_char_sequencer.sv - directed self-checking bench for morse_char_sequencer
module tb_morse_char_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    morse_char_sequencer_if bus1();
    morse_char_sequencer_if bus3();
    logic key1, busy1, done1;
    logic key3, busy3, done3;
`ifdef MORSE_BEACON_EN
    logic bcn1 = 1'b0;
    logic bcn3 = 1'b0;
`endif

    morse_char_sequencer #(.UNIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave),
`ifdef MORSE_BEACON_EN
        .beacon_en(bcn1),
`endif
        .key_out(key1), .busy(busy1), .char_done(done1)
    );

    morse_char_sequencer #(.UNIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3.slave),
`ifdef MORSE_BEACON_EN
        .beacon_en(bcn3),
`endif
        .key_out(key3), .busy(busy3), .char_done(done3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [29:0] bb_key;
        logic [29:0] bb_done;
        logic [1:0]  bb_codes [6];
        logic [11:0] o_units;
        logic [31:0] bcn_pat;
        logic [5:0]  s_pat;
        logic        rdy;
        int          idx;
        int          n_done;

        s_pat   = 6'b101010;
        bb_key  = 30'b101010_00_111011101110_00_101010_00;
        bb_done = 30'b000001_01_000000000001_01_000001_01;
        bb_codes[0] = 2'b00; bb_codes[1] = 2'b10; bb_codes[2] = 2'b01;
        bb_codes[3] = 2'b10; bb_codes[4] = 2'b00; bb_codes[5] = 2'b10;
        o_units = 12'b111011101110;
        bcn_pat = 32'hA8EEE2A0;

        bus1.char_valid = 1'b0; bus1.char_code = 2'b00;
        bus3.char_valid = 1'b0; bus3.char_code = 2'b00;

        // Reset state
        step();
        chk("rst_key", key1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_ready", bus1.char_ready, 0);
        rst = 1'b0;
        step();
        chk("idle_ready", bus1.char_ready, 1);

        // Single S
        bus1.char_valid = 1'b1; bus1.char_code = 2'b00;
        step();
        bus1.char_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("s_key[%0d]", i), key1, s_pat[5-i]);
            chk($sformatf("s_done[%0d]", i), done1, (i == 5));
            chk($sformatf("s_busy[%0d]", i), busy1, 1);
            step();
        end
        chk("s_busy_after", busy1, 0);
        chk("s_key_after", key1, 0);

        // Back-to-back stream S GAP O GAP S GAP
        idx = 0; n_done = 0;
        bus1.char_valid = 1'b1; bus1.char_code = bb_codes[0];
        for (int c = 0; c < 30; c++) begin
            rdy = bus1.char_ready;
            step();
            if (rdy && bus1.char_valid) begin
                idx++;
                if (idx < 6) bus1.char_code = bb_codes[idx];
                else bus1.char_valid = 1'b0;
            end
            if (done1) n_done++;
            chk($sformatf("bb_key[%0d]", c), key1, bb_key[29-c]);
            chk($sformatf("bb_done[%0d]", c), done1, bb_done[29-c]);
        end
        step();
        chk("bb_accepts", idx, 6);
        chk("bb_done_count", n_done, 6);
        chk("bb_busy_after", busy1, 0);

        // Code wiggling while S is in progress; only the char_done-cycle code counts
        bus1.char_valid = 1'b1; bus1.char_code = 2'b00;
        step();
        for (int i = 0; i < 6; i++) begin
            bus1.char_valid = 1'b1;
            bus1.char_code  = (i == 5) ? 2'b01 : ((i % 2) != 0 ? 2'b00 : 2'b10);
            chk($sformatf("wig_ready[%0d]", i), bus1.char_ready, (i == 5));
            step();
        end
        bus1.char_valid = 1'b0; bus1.char_code = 2'b00;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("wig_o_key[%0d]", j), key1, (j < 3));
            step();
        end
        for (int k = 0; k < 40 && busy1; k++) step();
        chk("wig_drain", busy1, 0);

        // Asynchronous reset in the middle of an O dash
        bus1.char_valid = 1'b1; bus1.char_code = 2'b01;
        step();
        bus1.char_valid = 1'b0;
        step();
        chk("o_dash_key", key1, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_key", key1, 0);
        chk("arst_busy", busy1, 0);
        step();
        rst = 1'b0;
        step();
        chk("arst_busy_after", busy1, 0);
        chk("arst_ready_after", bus1.char_ready, 1);
        chk("arst_key_after", key1, 0);

        // UNIT_CYCLES=3, single O
        bus3.char_valid = 1'b1; bus3.char_code = 2'b01;
        step();
        bus3.char_valid = 1'b0;
        for (int c = 0; c < 36; c++) begin
            chk($sformatf("u3_key[%0d]", c), key3, o_units[11 - c/3]);
            chk($sformatf("u3_done[%0d]", c), done3, (c == 35));
            step();
        end
        chk("u3_busy_after", busy3, 0);

`ifdef MORSE_BEACON_EN
        // Autonomous beacon
        bcn1 = 1'b1;
        bus1.char_valid = 1'b1; bus1.char_code = 2'b01;
        step();
        for (int c = 0; c < 60; c++) begin
            chk($sformatf("bcn_key[%0d]", c), key1, bcn_pat[31 - (c % 32)]);
            chk($sformatf("bcn_ready[%0d]", c), bus1.char_ready, 0);
            step();
        end
        bcn1 = 1'b0;
        bus1.char_valid = 1'b0;
        for (int k = 0; k < 40 && busy1; k++) step();
        chk("bcn_drain", busy1, 0);
        chk("bcn_ready_after", bus1.char_ready, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
